// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
// Saturation is compiled in when MATMUL_SAT_EN is defined.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Wide signed carrier used when reducing a dot-product sum to OUT_BITS.
    localparam int unsigned WIDE_BITS = 64;
    typedef logic signed [WIDE_BITS-1:0] wide_t;

    typedef struct packed {
        logic  clip;
        wide_t val;
    } sat_res_t;

    // Sum width that a SIZE-term signed dot product can never overflow.
    function automatic int unsigned sum_bits(input int unsigned size, input int unsigned in_bits);
        return 2 * in_bits + $clog2(size);
    endfunction

    // Clamp sum to the signed out_bits range and report whether it clipped.
    function automatic sat_res_t sat_trunc(input wide_t sum, input int unsigned out_bits);
        sat_res_t res;
        wide_t    hi;
        wide_t    lo;
        hi = (wide_t'(1) <<< (out_bits - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (out_bits - 1));
        res.clip = 1'b0;
        res.val  = sum;
        if (sum > hi) begin
            res.clip = 1'b1;
            res.val  = hi;
        end else if (sum < lo) begin
            res.clip = 1'b1;
            res.val  = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/matmul_dot.sv
// Combinational signed SIZE-term dot product at full (non-overflowing) width.
module matmul_dot
    import matmul_pkg::*;
#(
    parameter int unsigned SIZE    = 3,
    parameter int unsigned IN_BITS = 8
) (
    input  logic [SIZE-1:0][IN_BITS-1:0]              row,
    input  logic [SIZE-1:0][IN_BITS-1:0]              col,
    output logic signed [sum_bits(SIZE, IN_BITS)-1:0] sum
);

    localparam int unsigned SW = sum_bits(SIZE, IN_BITS);

    logic signed [2*IN_BITS-1:0] prod;
    logic signed [SW-1:0]        acc;

    // Accumulate the sign-extended products of the two vectors.
    always_comb begin
        acc  = '0;
        prod = '0;
        for (int unsigned k = 0; k < SIZE; k++) begin
            prod = $signed(row[k]) * $signed(col[k]);
            acc  = acc + SW'(prod);
        end
        sum = acc;
    end

endmodule

// File: rtl/matrix_mult_seq.sv
// Handshaked sequential SIZE x SIZE signed matrix multiplier, one element per cycle.
// Optional clamping of results is enabled by defining MATMUL_SAT_EN.
module matrix_mult_seq
    import matmul_pkg::*;
#(
    parameter int unsigned SIZE      = 3,
    parameter int unsigned IN_BITS   = 8,
    parameter int unsigned OUT_BITS  = IN_BITS,
    parameter int unsigned FRAC_BITS = 0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0]  a,
    input  logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0]  b,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [SIZE-1:0][SIZE-1:0][OUT_BITS-1:0] out,
    output logic                                    sat_flag
);

    localparam int unsigned SW  = sum_bits(SIZE, IN_BITS);
    localparam int unsigned NEL = SIZE * SIZE;
    localparam int unsigned CW  = $clog2(NEL);
    localparam int unsigned IW  = $clog2(SIZE);

    state_t                               state;
    logic [CW-1:0]                        cnt;
    logic [IW-1:0]                        ri;
    logic [IW-1:0]                        ci;
    logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] a_q;
    logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] b_q;

    logic [SIZE-1:0][IN_BITS-1:0] row_v;
    logic [SIZE-1:0][IN_BITS-1:0] col_v;
    logic signed [SW-1:0]         sum;
    logic signed [SW-1:0]         shifted;
    wide_t                        wide;
    logic [OUT_BITS-1:0]          elem;
    logic                         clip;
    logic                         unused_bits;

    // Select row ri of a_q and column ci of b_q for the dot product.
    always_comb begin
        row_v = a_q[ri];
        col_v = '0;
        for (int unsigned k = 0; k < SIZE; k++) begin
            col_v[k] = b_q[k][ci];
        end
    end

    matmul_dot #(
        .SIZE    (SIZE),
        .IN_BITS (IN_BITS)
    ) u_dot (
        .row (row_v),
        .col (col_v),
        .sum (sum)
    );

    // Scale the sum and reduce it to OUT_BITS by clamping or wrap-around.
    always_comb begin
        shifted = sum >>> FRAC_BITS;
        wide    = WIDE_BITS'(shifted);
`ifdef MATMUL_SAT_EN
        begin
            sat_res_t r;
            r           = sat_trunc(wide, OUT_BITS);
            elem        = r.val[OUT_BITS-1:0];
            clip        = r.clip;
            unused_bits = ^r.val[WIDE_BITS-1:OUT_BITS];
        end
`else
        elem        = wide[OUT_BITS-1:0];
        clip        = 1'b0;
        unused_bits = ^wide[WIDE_BITS-1:OUT_BITS];
`endif
    end

    // Control FSM with registered handshake, result and flag outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            sat_flag  <= 1'b0;
            cnt       <= '0;
            ri        <= '0;
            ci        <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        cnt      <= '0;
                        ri       <= '0;
                        ci       <= '0;
                        sat_flag <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    out[ri][ci] <= elem;
                    sat_flag    <= sat_flag | clip;
                    if (cnt == CW'(NEL - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (ci == IW'(SIZE - 1)) begin
                            ci <= '0;
                            ri <= ri + 1'b1;
                        end else begin
                            ci <= ci + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
